// File: rtl/sensor_acq_seq_pkg.sv
// sensor_acq_seq_pkg: shared state encoding, default sizes and sensor slot indices
package sensor_acq_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} acq_state_e;

    localparam int N_SENSORS_DEF = 10;
    localparam int DLY_W_DEF     = 16;
    localparam int TO_W_DEF      = 16;

    localparam int SENS_ADC   = 0;
    localparam int SENS_ENC   = 1;
    localparam int SENS_AMDS0 = 2;
    localparam int SENS_AMDS1 = 3;
    localparam int SENS_AMDS2 = 4;
    localparam int SENS_AMDS3 = 5;
    localparam int SENS_EDDY0 = 6;
    localparam int SENS_EDDY1 = 7;
    localparam int SENS_EDDY2 = 8;
    localparam int SENS_EDDY3 = 9;

endpackage

// File: rtl/sensor_acq_slot.sv
// sensor_acq_slot: per-sensor start compare, done edge capture, wait counter and timeout
module sensor_acq_slot
    import sensor_acq_seq_pkg::*;
#(
    parameter int DLY_W = DLY_W_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic             en,
    input  logic [DLY_W-1:0] dly,
    input  logic [31:0]      elapsed,
    input  logic [TO_W-1:0]  timeout_cycles,
    input  logic             done_raw,
    output logic             start,
    output logic             done_d,
    output logic             done_q,
    output logic             timeout_flag
);

    logic            done_prev;
    logic            started;
    logic [TO_W-1:0] wait_cnt;
    logic            rise;
    logic            to_hit;
    logic            done_set;
    logic            to_set;

    // started only goes high after the start cycle, so edges up to and including it are ignored
    assign start    = run && en && elapsed == 32'(dly);
    assign rise     = done_raw && !done_prev;
    assign to_hit   = timeout_cycles != '0 && wait_cnt == timeout_cycles;
    assign done_set = run && started && !done_q && rise;
    assign to_set   = run && started && !done_q && !rise && to_hit;
    assign done_d   = done_q || done_set || to_set;

    // wait_cnt reads k in the k-th cycle after start; a real done edge beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            done_prev    <= 1'b0;
            started      <= 1'b0;
            wait_cnt     <= '0;
            done_q       <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            done_prev <= done_raw;
            if (clr) begin
                started      <= 1'b0;
                wait_cnt     <= '0;
                done_q       <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                if (start) begin
                    started  <= 1'b1;
                    wait_cnt <= TO_W'(1);
                end else if (run && started && !done_q && wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (done_set || to_set) done_q <= 1'b1;
                if (to_set) timeout_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_acq_sequencer.sv
// sensor_acq_sequencer: staggered sensor starts per trigger with timed-out done tracking; optional SENSOR_ACQ_SEQ_CYCLE_COUNT_EN
module sensor_acq_sequencer
    import sensor_acq_seq_pkg::*;
#(
    parameter int N_SENSORS = N_SENSORS_DEF,
    parameter int DLY_W     = DLY_W_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trigger,
    input  logic [N_SENSORS-1:0]       en_bits,
    input  logic [N_SENSORS*DLY_W-1:0] start_dly,
    input  logic [TO_W-1:0]            timeout_cycles,
    input  logic [N_SENSORS-1:0]       sensor_done,
    output logic [N_SENSORS-1:0]       sensor_start,
    output logic [N_SENSORS-1:0]       done_q,
    output logic [N_SENSORS-1:0]       timeout_flags,
    output logic                       busy,
    output logic                       acq_done,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic [31:0]                last_acq_cycles
);

    acq_state_e                 state;
    logic [N_SENSORS-1:0]       en_q;
    logic [N_SENSORS*DLY_W-1:0] dly_q;
    logic [31:0]                elapsed;
    logic [N_SENSORS-1:0]       done_d;
    logic                       run;
    logic                       arm;
    logic                       finish;

    // completion looks at next-cycle done state so acq_done lands the cycle after the last done edge
    assign run    = state == RUN;
    assign arm    = !run && trigger && en_bits != '0;
    assign finish = run && (done_d & en_q) == en_q;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_slot
        sensor_acq_slot #(.DLY_W(DLY_W), .TO_W(TO_W)) u_slot (
            .clk            (clk),
            .rst            (rst),
            .clr            (arm),
            .run            (run),
            .en             (en_q[i]),
            .dly            (dly_q[i*DLY_W +: DLY_W]),
            .elapsed        (elapsed),
            .timeout_cycles (timeout_cycles),
            .done_raw       (sensor_done[i]),
            .start          (sensor_start[i]),
            .done_d         (done_d[i]),
            .done_q         (done_q[i]),
            .timeout_flag   (timeout_flags[i])
        );
    end

    // sequencing FSM with elapsed counter and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            en_q     <= '0;
            dly_q    <= '0;
            elapsed  <= '0;
            busy     <= 1'b0;
            acq_done <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            acq_done <= 1'b0;
            if (run && trigger) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
            case (state)
                RUN: begin
                    elapsed <= elapsed + {31'b0, elapsed != '1};
                    if (finish) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        acq_done <= 1'b1;
                    end
                end
                default: begin
                    if (arm) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        en_q    <= en_bits;
                        dly_q   <= start_dly;
                        elapsed <= '0;
                    end
                end
            endcase
        end
    end

`ifdef SENSOR_ACQ_SEQ_CYCLE_COUNT_EN
    // run length from first RUN cycle through the completion cycle
    always_ff @(posedge clk) begin
        if (rst) last_acq_cycles <= '0;
        else if (finish) last_acq_cycles <= elapsed + {31'b0, elapsed != '1};
    end
`else
    assign last_acq_cycles = '0;
`endif

endmodule

// File: tb/tb_sensor_acq_sequencer.sv
// tb_sensor_acq_sequencer: directed scenarios with hand-computed cycle expectations
module tb_sensor_acq_sequencer;

    localparam int N = 10;
`ifdef SENSOR_ACQ_SEQ_CYCLE_COUNT_EN
    localparam logic [31:0] EXP_LAST = 32'd30;
`else
    localparam logic [31:0] EXP_LAST = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic [N-1:0]  en_bits = '0;
    logic [N*16-1:0] start_dly = '0;
    logic [15:0]   timeout_cycles = '0;
    logic [N-1:0]  sensor_done = '0;
    logic [N-1:0]  sensor_start;
    logic [N-1:0]  done_q;
    logic [N-1:0]  timeout_flags;
    logic          busy;
    logic          acq_done;
    logic          overrun;
    logic          overrun_clr = 1'b0;
    logic [31:0]   last_acq_cycles;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0;
    int rise_at[N];
    int fall_at[N];
    int rise2_at[N];
    int start_at[N];
    int start_cnt[N];
    int acq_at;
    int acq_cnt;

    sensor_acq_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .trigger         (trigger),
        .en_bits         (en_bits),
        .start_dly       (start_dly),
        .timeout_cycles  (timeout_cycles),
        .sensor_done     (sensor_done),
        .sensor_start    (sensor_start),
        .done_q          (done_q),
        .timeout_flags   (timeout_flags),
        .busy            (busy),
        .acq_done        (acq_done),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr),
        .last_acq_cycles (last_acq_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic lvl(int i, int c);
        return (rise_at[i] >= 0 && c >= rise_at[i] && (fall_at[i] < 0 || c < fall_at[i]))
            || (rise2_at[i] >= 0 && c >= rise2_at[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            sensor_done[i] = lvl(i, cyc);
            if (sensor_start[i]) begin
                if (start_at[i] < 0) start_at[i] = cyc;
                start_cnt[i]++;
            end
        end
        if (acq_done) begin
            acq_at = cyc;
            acq_cnt++;
        end
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_sched();
        for (int i = 0; i < N; i++) begin
            rise_at[i] = -1;
            fall_at[i] = -1;
            rise2_at[i] = -1;
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < N; i++) begin
            start_at[i] = -1;
            start_cnt[i] = 0;
        end
        acq_at = -1;
        acq_cnt = 0;
    endtask

    task automatic set_dly(input int i, input int v);
        start_dly[i*16 +: 16] = 16'(v);
    endtask

    task automatic fire(input logic [N-1:0] en);
        en_bits = en;
        trigger = 1'b1;
        clear_obs();
        tick();
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_sched();
        clear_obs();
        tick();
        tick();
        total++; if ({busy, acq_done, overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, acq_done, overrun}); end
        total++; if ({sensor_start, done_q, timeout_flags} !== '0) begin bad++; $display("FAIL reset_vectors got=%h exp=0", {sensor_start, done_q, timeout_flags}); end
        total++; if (last_acq_cycles !== 32'd0) begin bad++; $display("FAIL reset_last got=%0d exp=0", last_acq_cycles); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stagger();
        clear_sched();
        timeout_cycles = 16'd0;
        start_dly = '0;
        set_dly(0, 0);
        set_dly(1, 5);
        t0 = cyc;
        rise_at[0] = t0 + 20;
        rise_at[1] = t0 + 30;
        fire(10'h003);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stagger_busy got=%b exp=1", busy); end
        tick_to(t0 + 21);
        total++; if (done_q !== 10'h001) begin bad++; $display("FAIL stagger_done_mid got=%h exp=001", done_q); end
        tick_to(t0 + 31);
        total++; if (acq_done !== 1'b1) begin bad++; $display("FAIL stagger_acq got=%b exp=1", acq_done); end
        tick_to(t0 + 40);
        total++; if (start_at[0] !== t0 + 1) begin bad++; $display("FAIL stagger_start0 got=%0d exp=%0d", start_at[0] - t0, 1); end
        total++; if (start_at[1] !== t0 + 6) begin bad++; $display("FAIL stagger_start1 got=%0d exp=%0d", start_at[1] - t0, 6); end
        total++; if (start_cnt[0] + start_cnt[1] !== 2) begin bad++; $display("FAIL stagger_start_count got=%0d exp=2", start_cnt[0] + start_cnt[1]); end
        total++; if (acq_at !== t0 + 31 || acq_cnt !== 1) begin bad++; $display("FAIL stagger_acq_at got=%0d/%0d exp=31/1", acq_at - t0, acq_cnt); end
        total++; if (done_q !== 10'h003 || timeout_flags !== '0) begin bad++; $display("FAIL stagger_done got=%h/%h exp=003/000", done_q, timeout_flags); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stagger_idle got=%b exp=0", busy); end
        total++; if (last_acq_cycles !== EXP_LAST) begin bad++; $display("FAIL stagger_last got=%0d exp=%0d", last_acq_cycles, EXP_LAST); end
    endtask

    task automatic test_timeout();
        clear_sched();
        tick();
        timeout_cycles = 16'd50;
        start_dly = '0;
        set_dly(2, 3);
        t0 = cyc;
        fire(10'h004);
        tick_to(t0 + 54);
        total++; if (done_q !== 10'h000) begin bad++; $display("FAIL timeout_early got=%h exp=000", done_q); end
        tick();
        total++; if (start_at[2] !== t0 + 4) begin bad++; $display("FAIL timeout_start got=%0d exp=4", start_at[2] - t0); end
        total++; if (done_q !== 10'h004 || timeout_flags !== 10'h004) begin bad++; $display("FAIL timeout_set got=%h/%h exp=004/004", done_q, timeout_flags); end
        total++; if (acq_done !== 1'b1) begin bad++; $display("FAIL timeout_acq got=%b exp=1", acq_done); end
    endtask

    task automatic test_edge_on_timeout();
        clear_sched();
        t0 = cyc;
        rise_at[2] = t0 + 54;
        fire(10'h004);
        total++; if (done_q !== '0 || timeout_flags !== '0) begin bad++; $display("FAIL tie_cleared got=%h/%h exp=000/000", done_q, timeout_flags); end
        tick_to(t0 + 55);
        total++; if (done_q !== 10'h004 || timeout_flags !== 10'h000) begin bad++; $display("FAIL tie_done_wins got=%h/%h exp=004/000", done_q, timeout_flags); end
        total++; if (acq_done !== 1'b1) begin bad++; $display("FAIL tie_acq got=%b exp=1", acq_done); end
    endtask

    task automatic test_overrun();
        clear_sched();
        tick();
        timeout_cycles = 16'd0;
        start_dly = '0;
        t0 = cyc;
        rise_at[0] = t0 + 10;
        fire(10'h001);
        tick_to(t0 + 3);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        total++; if (overrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b%b exp=11", overrun, busy); end
        tick_to(t0 + 11);
        total++; if (acq_done !== 1'b1 || start_cnt[0] !== 1) begin bad++; $display("FAIL ovr_no_restart got=%b/%0d exp=1/1", acq_done, start_cnt[0]); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        clear_sched();
        tick();
        t0 = cyc;
        rise_at[0] = t0 + 5;
        fire(10'h001);
        total++; if (done_q !== '0 || busy !== 1'b1) begin bad++; $display("FAIL ovr_rerun got=%h/%b exp=000/1", done_q, busy); end
        tick();
        trigger = 1'b1;
        overrun_clr = 1'b1;
        tick();
        trigger = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        tick();
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear2 got=%b exp=0", overrun); end
        tick_to(t0 + 6);
        total++; if (acq_done !== 1'b1 || done_q !== 10'h001) begin bad++; $display("FAIL ovr_rerun_done got=%b/%h exp=1/001", acq_done, done_q); end
    endtask

    task automatic test_level_held();
        clear_sched();
        start_dly = '0;
        set_dly(0, 2);
        t0 = cyc;
        rise_at[0] = t0;
        fall_at[0] = t0 + 10;
        rise2_at[0] = t0 + 15;
        sensor_done[0] = 1'b1;
        fire(10'h001);
        tick_to(t0 + 15);
        total++; if (acq_cnt !== 0 || done_q !== 10'h000) begin bad++; $display("FAIL held_wait got=%0d/%h exp=0/000", acq_cnt, done_q); end
        tick();
        total++; if (acq_done !== 1'b1 || done_q !== 10'h001) begin bad++; $display("FAIL held_fresh_edge got=%b/%h exp=1/001", acq_done, done_q); end
        fire(10'h000);
        tick();
        tick();
        total++; if (busy !== 1'b0 || done_q !== 10'h001) begin bad++; $display("FAIL empty_trigger got=%b/%h exp=0/001", busy, done_q); end
        total++; if (start_cnt[0] !== 0 || acq_cnt !== 0) begin bad++; $display("FAIL empty_no_activity got=%0d/%0d exp=0/0", start_cnt[0], acq_cnt); end
    endtask

    task automatic test_reset_mid_run();
        clear_sched();
        tick();
        start_dly = '0;
        t0 = cyc;
        rise_at[5] = t0 + 2;
        fire(10'h3FF);
        total++; if (sensor_start !== 10'h3FF) begin bad++; $display("FAIL rst_run_start got=%h exp=3ff", sensor_start); end
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        total++; if (done_q !== 10'h020 || overrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_run_pre got=%h/%b/%b exp=020/1/1", done_q, overrun, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({busy, acq_done, overrun, sensor_start, done_q, timeout_flags} !== '0) begin bad++; $display("FAIL rst_run_outputs got=%h exp=0", {busy, acq_done, overrun, sensor_start, done_q, timeout_flags}); end
        total++; if (last_acq_cycles !== 32'd0) begin bad++; $display("FAIL rst_run_last got=%0d exp=0", last_acq_cycles); end
        for (int k = 0; k < 20; k++) tick();
        total++; if (acq_cnt !== 0 || busy !== 1'b0 || sensor_start !== '0) begin bad++; $display("FAIL rst_run_idle got=%0d/%b/%h exp=0/0/000", acq_cnt, busy, sensor_start); end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_timeout();
        test_edge_on_timeout();
        test_overrun();
        test_level_held();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
